// File: rtl/intf_apb_pkg.sv
// Shared types and constants for the SPI/I2C to APB access arbiter.
// The select decode lives here so the bench and the RTL agree on the slave map.
package intf_apb_pkg;

    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;
    localparam int NSLV    = 4;
    localparam int SEL_MSB = 7;
    localparam int SEL_LSB = 6;
    localparam int WAIT_W  = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef enum logic {
        REQ_SPI = 1'b0,
        REQ_I2C = 1'b1
    } req_id_t;

    // Top two address bits pick one of the four peripherals.
    function automatic logic [NSLV-1:0] sel_decode(input logic [ADDR_W-1:0] addr);
        logic [NSLV-1:0] sel;
        sel = '0;
        sel[addr[SEL_MSB:SEL_LSB]] = 1'b1;
        return sel;
    endfunction

endpackage

// File: rtl/intf_rr_arb2.sv
// Two-way round-robin picker; a masked requester is ignored for the current cycle.
// The pointer remembers the last grant so a tie goes to the other requester.
module intf_rr_arb2
    import intf_apb_pkg::*;
(
    input  logic    pclk,
    input  logic    prst_n,
    input  logic    req_spi,
    input  logic    req_i2c,
    input  logic    mask_spi,
    input  logic    mask_i2c,
    input  logic    take,
    output logic    gnt_vld,
    output req_id_t gnt_id
);

    req_id_t last_q;
    logic    eff_spi;
    logic    eff_i2c;

    assign eff_spi = req_spi & ~mask_spi;
    assign eff_i2c = req_i2c & ~mask_i2c;
    assign gnt_vld = eff_spi | eff_i2c;

    always_comb begin
        gnt_id = REQ_SPI;
        if (eff_spi && eff_i2c) begin
            gnt_id = (last_q == REQ_I2C) ? REQ_SPI : REQ_I2C;
        end else if (eff_i2c) begin
            gnt_id = REQ_I2C;
        end
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            last_q <= REQ_I2C;
        end else if (take && gnt_vld) begin
            last_q <= gnt_id;
        end
    end

endmodule

// File: rtl/intf_apb_arbiter.sv
// Shares one APB master port between the SPI and I2C slave front-ends:
// round-robin grant, SETUP/ACCESS sequencing, slave select decode and read return.
module intf_apb_arbiter
    import intf_apb_pkg::*;
#(
    parameter int UDLY     = 1,
    parameter int ACC_WAIT = 0
) (
    input  logic              pclk,
    input  logic              prst_n,
    input  logic              spi_req,
    input  logic              spi_wr,
    input  logic [ADDR_W-1:0] spi_addr,
    input  logic [DATA_W-1:0] spi_wdata,
    output logic              spi_done,
    output logic [DATA_W-1:0] spi_rdata,
    input  logic              i2c_req,
    input  logic              i2c_wr,
    input  logic [ADDR_W-1:0] i2c_addr,
    input  logic [DATA_W-1:0] i2c_wdata,
    output logic              i2c_done,
    output logic [DATA_W-1:0] i2c_rdata,
    output logic              psel0,
    output logic              psel1,
    output logic              psel2,
    output logic              psel3,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata0,
    input  logic [DATA_W-1:0] prdata1,
    input  logic [DATA_W-1:0] prdata2,
    input  logic [DATA_W-1:0] prdata3
);

    // The wait counter is only 3 bits wide and a negative delay is meaningless.
    if (ACC_WAIT < 0 || ACC_WAIT > 7 || UDLY < 0) begin : g_bad_param
        $error("intf_apb_arbiter: ACC_WAIT must be 0..7 and UDLY non-negative");
    end

    state_t            state_q, state_nxt;
    req_id_t           owner_q, owner_nxt;
    logic [WAIT_W-1:0] wait_q, wait_nxt;
    logic [NSLV-1:0]   psel_q, psel_nxt;
    logic              penable_q, penable_nxt;
    logic              pwrite_q, pwrite_nxt;
    logic [ADDR_W-1:0] paddr_q, paddr_nxt;
    logic [DATA_W-1:0] pwdata_q, pwdata_nxt;
    logic              spi_done_q, spi_done_nxt;
    logic              i2c_done_q, i2c_done_nxt;
    logic [DATA_W-1:0] spi_rdata_q, spi_rdata_nxt;
    logic [DATA_W-1:0] i2c_rdata_q, i2c_rdata_nxt;
    logic [DATA_W-1:0] prdata_sel;
    logic              gnt_vld;
    req_id_t           gnt_id;

    // A requester still showing done is masked so a late-dropped req is not re-granted.
    intf_rr_arb2 u_arb (
        .pclk     (pclk),
        .prst_n   (prst_n),
        .req_spi  (spi_req),
        .req_i2c  (i2c_req),
        .mask_spi (spi_done_q),
        .mask_i2c (i2c_done_q),
        .take     (state_q == IDLE),
        .gnt_vld  (gnt_vld),
        .gnt_id   (gnt_id)
    );

    always_comb begin
        prdata_sel = '0;
        case (paddr_q[SEL_MSB:SEL_LSB])
            2'd0: prdata_sel = prdata0;
            2'd1: prdata_sel = prdata1;
            2'd2: prdata_sel = prdata2;
            2'd3: prdata_sel = prdata3;
            default: prdata_sel = '0;
        endcase
    end

    always_comb begin
        state_nxt     = state_q;
        owner_nxt     = owner_q;
        wait_nxt      = wait_q;
        psel_nxt      = psel_q;
        penable_nxt   = penable_q;
        pwrite_nxt    = pwrite_q;
        paddr_nxt     = paddr_q;
        pwdata_nxt    = pwdata_q;
        spi_done_nxt  = 1'b0;
        i2c_done_nxt  = 1'b0;
        spi_rdata_nxt = spi_rdata_q;
        i2c_rdata_nxt = i2c_rdata_q;
        case (state_q)
            IDLE: begin
                psel_nxt    = '0;
                penable_nxt = 1'b0;
                if (gnt_vld) begin
                    owner_nxt = gnt_id;
                    if (gnt_id == REQ_SPI) begin
                        paddr_nxt  = spi_addr;
                        pwrite_nxt = spi_wr;
                        pwdata_nxt = spi_wdata;
                        psel_nxt   = sel_decode(spi_addr);
                    end else begin
                        paddr_nxt  = i2c_addr;
                        pwrite_nxt = i2c_wr;
                        pwdata_nxt = i2c_wdata;
                        psel_nxt   = sel_decode(i2c_addr);
                    end
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                penable_nxt = 1'b1;
                wait_nxt    = WAIT_W'(ACC_WAIT);
                state_nxt   = ACCESS;
            end
            ACCESS: begin
                if (wait_q != '0) begin
                    wait_nxt = wait_q - 1'b1;
                end else begin
                    if (owner_q == REQ_SPI) begin
                        spi_done_nxt = 1'b1;
                        if (!pwrite_q) spi_rdata_nxt = prdata_sel;
                    end else begin
                        i2c_done_nxt = 1'b1;
                        if (!pwrite_q) i2c_rdata_nxt = prdata_sel;
                    end
                    psel_nxt    = '0;
                    penable_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            default: begin
                psel_nxt    = '0;
                penable_nxt = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge prst_n) begin
        if (!prst_n) begin
            state_q     <= IDLE;
            owner_q     <= REQ_SPI;
            wait_q      <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            spi_done_q  <= 1'b0;
            i2c_done_q  <= 1'b0;
            spi_rdata_q <= '0;
            i2c_rdata_q <= '0;
        end else begin
            state_q     <= state_nxt;
            owner_q     <= owner_nxt;
            wait_q      <= wait_nxt;
            psel_q      <= psel_nxt;
            penable_q   <= penable_nxt;
            pwrite_q    <= pwrite_nxt;
            paddr_q     <= paddr_nxt;
            pwdata_q    <= pwdata_nxt;
            spi_done_q  <= spi_done_nxt;
            i2c_done_q  <= i2c_done_nxt;
            spi_rdata_q <= spi_rdata_nxt;
            i2c_rdata_q <= i2c_rdata_nxt;
        end
    end

    assign psel0     = psel_q[0];
    assign psel1     = psel_q[1];
    assign psel2     = psel_q[2];
    assign psel3     = psel_q[3];
    assign penable   = penable_q;
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign spi_done  = spi_done_q;
    assign spi_rdata = spi_rdata_q;
    assign i2c_done  = i2c_done_q;
    assign i2c_rdata = i2c_rdata_q;

endmodule

// File: tb/tb_intf_apb_arbiter.sv
// Directed bench for intf_apb_arbiter: one instance with no wait states,
// a second with ACC_WAIT=3 driven only from its I2C side.
module tb_intf_apb_arbiter;

    logic        pclk;
    logic        prst_n;
    logic        spi_req, spi_wr, i2c_req, i2c_wr;
    logic [7:0]  spi_addr, i2c_addr;
    logic [15:0] spi_wdata, i2c_wdata;
    logic [15:0] prdata0, prdata1, prdata2, prdata3;
    logic        i2c_req3, i2c_wr3;
    logic [7:0]  i2c_addr3;
    logic [15:0] i2c_wdata3;

    logic        spi_done, i2c_done, penable, pwrite;
    logic [15:0] spi_rdata, i2c_rdata, pwdata;
    logic [7:0]  paddr;
    logic        psel0, psel1, psel2, psel3;
    logic [3:0]  psel_v;

    logic        spi_done3, i2c_done3, penable3, pwrite3;
    logic [15:0] spi_rdata3, i2c_rdata3, pwdata3;
    logic [7:0]  paddr3;
    logic        psel0_3, psel1_3, psel2_3, psel3_3;
    logic [3:0]  psel3v;

    assign psel_v = {psel3, psel2, psel1, psel0};
    assign psel3v = {psel3_3, psel2_3, psel1_3, psel0_3};

    int n_cmp = 0;
    int n_bad = 0;

    intf_apb_arbiter #(.UDLY(1), .ACC_WAIT(0)) dut0 (
        .pclk(pclk), .prst_n(prst_n),
        .spi_req(spi_req), .spi_wr(spi_wr), .spi_addr(spi_addr), .spi_wdata(spi_wdata),
        .spi_done(spi_done), .spi_rdata(spi_rdata),
        .i2c_req(i2c_req), .i2c_wr(i2c_wr), .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata),
        .i2c_done(i2c_done), .i2c_rdata(i2c_rdata),
        .psel0(psel0), .psel1(psel1), .psel2(psel2), .psel3(psel3),
        .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .prdata0(prdata0), .prdata1(prdata1), .prdata2(prdata2), .prdata3(prdata3)
    );

    intf_apb_arbiter #(.UDLY(1), .ACC_WAIT(3)) dut3 (
        .pclk(pclk), .prst_n(prst_n),
        .spi_req(1'b0), .spi_wr(1'b0), .spi_addr(8'h00), .spi_wdata(16'h0000),
        .spi_done(spi_done3), .spi_rdata(spi_rdata3),
        .i2c_req(i2c_req3), .i2c_wr(i2c_wr3), .i2c_addr(i2c_addr3), .i2c_wdata(i2c_wdata3),
        .i2c_done(i2c_done3), .i2c_rdata(i2c_rdata3),
        .psel0(psel0_3), .psel1(psel1_3), .psel2(psel2_3), .psel3(psel3_3),
        .penable(penable3), .pwrite(pwrite3), .paddr(paddr3), .pwdata(pwdata3),
        .prdata0(prdata0), .prdata1(prdata1), .prdata2(prdata2), .prdata3(prdata3)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic        src;    // 0 = SPI, 1 = I2C
        logic        wr;
        logic [7:0]  addr;
        logic [15:0] wdata;
        logic [3:0]  sel;
        logic [15:0] rdata;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic post(input logic src, input logic wr, input logic [7:0] addr,
                        input logic [15:0] wdata);
        if (src == 1'b0) begin
            spi_req = 1'b1; spi_wr = wr; spi_addr = addr; spi_wdata = wdata;
        end else begin
            i2c_req = 1'b1; i2c_wr = wr; i2c_addr = addr; i2c_wdata = wdata;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " psel"},      {28'd0, psel_v}, 32'd0);
        chk({tag, " penable"},   {31'd0, penable}, 32'd0);
        chk({tag, " pwrite"},    {31'd0, pwrite}, 32'd0);
        chk({tag, " paddr"},     {24'd0, paddr}, 32'd0);
        chk({tag, " pwdata"},    {16'd0, pwdata}, 32'd0);
        chk({tag, " spi_done"},  {31'd0, spi_done}, 32'd0);
        chk({tag, " i2c_done"},  {31'd0, i2c_done}, 32'd0);
        chk({tag, " spi_rdata"}, {16'd0, spi_rdata}, 32'd0);
        chk({tag, " i2c_rdata"}, {16'd0, i2c_rdata}, 32'd0);
    endtask

    initial begin
        logic       act_done, oth_done;
        logic [15:0] act_rdata;
        logic [1:0] order[4];
        int         ndone, nsetup, ndouble;
        logic       saw_done;

        vecs[0] = '{1'b0, 1'b1, 8'h45, 16'hA5A5, 4'b0010, 16'h0000};
        vecs[1] = '{1'b0, 1'b0, 8'h05, 16'h0000, 4'b0001, 16'h1111};
        vecs[2] = '{1'b1, 1'b0, 8'h45, 16'h0000, 4'b0010, 16'h2222};
        vecs[3] = '{1'b0, 1'b0, 8'h8A, 16'h0000, 4'b0100, 16'h3333};
        vecs[4] = '{1'b1, 1'b0, 8'hC2, 16'h0000, 4'b1000, 16'h1234};
        vecs[5] = '{1'b1, 1'b1, 8'h80, 16'hBEEF, 4'b0100, 16'h1234};
        vecs[6] = '{1'b0, 1'b1, 8'hFF, 16'h0F0F, 4'b1000, 16'h3333};

        prdata0 = 16'h1111; prdata1 = 16'h2222; prdata2 = 16'h3333; prdata3 = 16'h1234;
        spi_req = 0; spi_wr = 0; spi_addr = 0; spi_wdata = 0;
        i2c_req = 0; i2c_wr = 0; i2c_addr = 0; i2c_wdata = 0;
        i2c_req3 = 0; i2c_wr3 = 0; i2c_addr3 = 0; i2c_wdata3 = 0;

        // Reset state
        prst_n = 1'b0;
        repeat (2) @(posedge pclk);
        #1 prst_n = 1'b1;
        tick();
        check_all_zero("reset");
        chk("reset psel dut3", {28'd0, psel3v}, 32'd0);
        chk("reset penable dut3", {31'd0, penable3}, 32'd0);
        chk("reset pwrite/paddr/pwdata dut3", {7'd0, pwrite3, paddr3, pwdata3}, 32'd0);
        chk("reset rdata dut3", {spi_rdata3, i2c_rdata3}, 32'd0);

        // Single transfers, zero wait states, covering all four selects
        for (int i = 0; i < 7; i++) begin
            post(vecs[i].src, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
            tick();
            chk($sformatf("v%0d setup psel", i), {28'd0, psel_v}, {28'd0, vecs[i].sel});
            chk($sformatf("v%0d setup penable", i), {31'd0, penable}, 32'd0);
            chk($sformatf("v%0d paddr", i), {24'd0, paddr}, {24'd0, vecs[i].addr});
            chk($sformatf("v%0d pwrite", i), {31'd0, pwrite}, {31'd0, vecs[i].wr});
            chk($sformatf("v%0d pwdata", i), {16'd0, pwdata}, {16'd0, vecs[i].wdata});
            tick();
            chk($sformatf("v%0d access psel", i), {28'd0, psel_v}, {28'd0, vecs[i].sel});
            chk($sformatf("v%0d access penable", i), {31'd0, penable}, 32'd1);
            tick();
            act_done  = vecs[i].src ? i2c_done : spi_done;
            oth_done  = vecs[i].src ? spi_done : i2c_done;
            act_rdata = vecs[i].src ? i2c_rdata : spi_rdata;
            chk($sformatf("v%0d done", i), {31'd0, act_done}, 32'd1);
            chk($sformatf("v%0d other done", i), {31'd0, oth_done}, 32'd0);
            chk($sformatf("v%0d rdata", i), {16'd0, act_rdata}, {16'd0, vecs[i].rdata});
            chk($sformatf("v%0d idle psel/penable", i), {27'd0, psel_v, penable}, 32'd0);
            chk($sformatf("v%0d paddr held", i), {24'd0, paddr}, {24'd0, vecs[i].addr});
            spi_req = 0; i2c_req = 0;
            tick();
            chk($sformatf("v%0d no regrant", i), {28'd0, psel_v}, 32'd0);
        end

        // Request held through its done cycle, dropped one cycle later
        post(1'b0, 1'b0, 8'h8A, 16'h0000);
        repeat (3) tick();
        chk("hold done", {31'd0, spi_done}, 32'd1);
        tick();
        chk("hold no setup", {28'd0, psel_v}, 32'd0);
        chk("hold done single", {31'd0, spi_done}, 32'd0);
        spi_req = 0;
        tick();
        chk("hold still idle", {28'd0, psel_v}, 32'd0);

        // ACC_WAIT=3 read from slave 3
        i2c_req3 = 1; i2c_wr3 = 0; i2c_addr3 = 8'hC2;
        for (int k = 1; k <= 5; k++) begin
            tick();
            chk($sformatf("w3 psel3 k%0d", k), {28'd0, psel3v}, 32'b1000);
            chk($sformatf("w3 penable k%0d", k), {31'd0, penable3}, (k >= 2) ? 32'd1 : 32'd0);
            chk($sformatf("w3 early done k%0d", k), {31'd0, i2c_done3}, 32'd0);
        end
        tick();
        chk("w3 done", {31'd0, i2c_done3}, 32'd1);
        chk("w3 rdata", {16'd0, i2c_rdata3}, 32'h1234);
        chk("w3 idle", {27'd0, psel3v, penable3}, 32'd0);
        chk("w3 paddr held", {24'd0, paddr3}, 32'hC2);
        chk("w3 no spi done", {31'd0, spi_done3}, 32'd0);
        i2c_req3 = 0;
        tick();
        chk("w3 no regrant", {28'd0, psel3v}, 32'd0);

        // Simultaneous requests after reset: SPI first, then alternate
        prst_n = 1'b0;
        tick();
        prst_n = 1'b1;
        tick();
        post(1'b0, 1'b0, 8'h05, 16'h0000);
        post(1'b1, 1'b0, 8'hC2, 16'h0000);
        for (int j = 0; j < 4; j++) order[j] = 2'd3;
        ndone = 0; nsetup = 0; ndouble = 0;
        for (int c = 0; c < 40 && ndone < 4; c++) begin
            tick();
            if (psel_v != 4'd0 && !penable) nsetup++;
            if (spi_done && i2c_done) ndouble++;
            if (spi_done) begin order[ndone] = 2'd0; ndone++; end
            else if (i2c_done) begin order[ndone] = 2'd1; ndone++; end
        end
        spi_req = 0; i2c_req = 0;
        chk("tie done count", ndone, 32'd4);
        chk("tie setup count", nsetup, 32'd4);
        chk("tie double done", ndouble, 32'd0);
        for (int j = 0; j < 4; j++)
            chk($sformatf("tie order %0d", j), {30'd0, order[j]}, (j % 2 == 0) ? 32'd0 : 32'd1);
        repeat (6) tick();

        // Reset during the ACCESS phase of an SPI read
        post(1'b0, 1'b0, 8'h45, 16'h0000);
        tick();
        tick();
        chk("abort in access", {31'd0, penable}, 32'd1);
        prst_n = 1'b0;
        #1;
        check_all_zero("abort");
        spi_req = 0;
        tick();
        prst_n = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (spi_done) saw_done = 1'b1;
        end
        chk("abort no done", {31'd0, saw_done}, 32'd0);
        post(1'b0, 1'b0, 8'h05, 16'h0000);
        post(1'b1, 1'b0, 8'hC2, 16'h0000);
        tick();
        chk("post-abort tie psel", {28'd0, psel_v}, 32'b0001);
        chk("post-abort tie paddr", {24'd0, paddr}, 32'h05);
        spi_req = 0; i2c_req = 0;
        repeat (8) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
